// File: rtl/spi_master.sv
// SPI master: one full-duplex MSB-first word per accepted stream command,
// with latched mode/prescale and a registered received-word output.
module spi_master #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      sclk,
    output logic                      mosi,
    input  logic                      miso,
    output logic                      cs_n,
    input  logic [1:0]                spi_mode,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      busy,
    output logic                      overrun_error
);

    localparam int EW = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

    state_t                    state;
    logic [PRESCALE_WIDTH-1:0] p_m1;
    logic [PRESCALE_WIDTH-1:0] cnt;
    logic [PRESCALE_WIDTH-1:0] p_new_m1;
    logic [DATA_WIDTH-1:0]     tx_sr;
    logic [DATA_WIDTH-1:0]     rx_sr;
    logic [EW-1:0]             edge_cnt;
    logic                      cpha;
    logic                      s_fire;
    logic                      cnt_done;

    // A prescale of 0 behaves like 1; the counter holds P-1 and expires at 0.
    assign p_new_m1 = (prescale == '0) ? '0 : prescale - 1'b1;
    assign s_fire   = s_axis_tvalid && s_axis_tready;
    assign cnt_done = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            s_axis_tready <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            sclk          <= 1'b0;
            mosi          <= 1'b0;
            cs_n          <= 1'b1;
            busy          <= 1'b0;
            overrun_error <= 1'b0;
            p_m1          <= '0;
            cnt           <= '0;
            tx_sr         <= '0;
            rx_sr         <= '0;
            edge_cnt      <= '0;
            cpha          <= 1'b0;
        end else begin
            overrun_error <= 1'b0;
            if (m_axis_tvalid && m_axis_tready)
                m_axis_tvalid <= 1'b0;

            case (state)
                IDLE: begin
                    sclk          <= spi_mode[1];
                    mosi          <= 1'b0;
                    cs_n          <= 1'b1;
                    busy          <= 1'b0;
                    s_axis_tready <= 1'b1;
                    if (s_fire) begin
                        s_axis_tready <= 1'b0;
                        tx_sr         <= s_axis_tdata;
                        rx_sr         <= '0;
                        cpha          <= spi_mode[0];
                        p_m1          <= p_new_m1;
                        cnt           <= p_new_m1;
                        edge_cnt      <= '0;
                        cs_n          <= 1'b0;
                        busy          <= 1'b1;
                        mosi          <= spi_mode[0] ? 1'b0 : s_axis_tdata[DATA_WIDTH-1];
                        state         <= SETUP;
                    end
                end

                // SETUP expiry produces edge 1, so both states share the edge logic.
                SETUP, XFER: begin
                    if (!cnt_done) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cnt      <= p_m1;
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (!edge_cnt[0]) begin
                            if (!cpha) begin
                                rx_sr <= {rx_sr[DATA_WIDTH-2:0], miso};
                            end else begin
                                mosi  <= tx_sr[DATA_WIDTH-1];
                                tx_sr <= tx_sr << 1;
                            end
                        end else begin
                            if (cpha) begin
                                rx_sr <= {rx_sr[DATA_WIDTH-2:0], miso};
                            end else if (edge_cnt != LAST_EDGE) begin
                                mosi  <= tx_sr[DATA_WIDTH-2];
                                tx_sr <= tx_sr << 1;
                            end
                        end
                        state <= (edge_cnt == LAST_EDGE) ? HOLD : XFER;
                    end
                end

                HOLD: begin
                    if (!cnt_done) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cnt           <= p_m1;
                        cs_n          <= 1'b1;
                        m_axis_tdata  <= rx_sr;
                        m_axis_tvalid <= 1'b1;
                        overrun_error <= m_axis_tvalid && !m_axis_tready;
                        state         <= GAP;
                    end
                end

                GAP: begin
                    if (!cnt_done) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
